// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//
// Direct-mapped, one-word-per-line instruction cache between the fetch stage
// (IF) and the instruction port of the memory controller (MC).
//
// A hit is answered one cycle after the request. A miss issues one
// single-word fetch to the MC, installs the returned word and forwards it to
// IF. A branch redirect (flush) during a miss drops the response, but the
// refill still completes and the line is still installed.
//
// Optional feature macro: ICACHE_PREFETCH_EN
//   When defined, a demand fill of address A followed by one idle cycle with
//   no request prefetches A+4 if that word is not already cached.
//
// Parameters
//   INDEX_W  index bits; 2**INDEX_W lines; index = pc[INDEX_W+1:2]
//   TAG_W    tag bits = pc[17:INDEX_W+2]; pc[31:18] are not part of the tag
//
// Ports
//   clk      in   system clock, all state updates on the rising edge
//   rst      in   asynchronous reset, active low
//   rdy      in   global ready; low freezes all state and outputs
//   if_req   in   IF request for if_pc, held until if_ok
//   if_pc    in   fetch address (bits [1:0] ignored)
//   flush    in   branch redirect; cancels the current request
//   if_ok    out  one-cycle pulse, if_inst is valid for the requested pc
//   if_inst  out  instruction word
//   mc_fe    out  fetch enable to the MC
//   mc_fpc   out  word-aligned fetch address
//   mc_ok    in   MC word-complete pulse
//   mc_pc    in   address of the completed word
//   mc_inst  in   completed word
// ---------------------------------------------------------------------------
module icache #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 16 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        if_ok,
  output logic [31:0] if_inst,
  output logic        mc_fe,
  output logic [31:0] mc_fpc,
  input  logic        mc_ok,
  input  logic [31:0] mc_pc,
  input  logic [31:0] mc_inst
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MISS     = 2'd1
`ifdef ICACHE_PREFETCH_EN
    ,S_PREFETCH = 2'd2
`endif
  } state_t;

  // Line storage: the valid bits need a reset, tag and data do not.
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  state_t             state_q,   state_d;
  logic [31:0]        req_pc_q,  req_pc_d;
  logic               drop_q,    drop_d;
  logic               if_ok_q,   if_ok_d;
  logic [31:0]        if_inst_q, if_inst_d;

`ifdef ICACHE_PREFETCH_EN
  // Set for exactly one active cycle after a demand fill; pf_pc_q holds A+4.
  logic               pf_cand_q, pf_cand_d;
  logic [31:0]        pf_pc_q,   pf_pc_d;
  logic [INDEX_W-1:0] pf_idx;
  logic [TAG_W-1:0]   pf_tag;
  logic               pf_hit;
`endif

  logic               fill_en;
  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               mc_match;
  logic               unused_pc_bits;

  // Combinational lookup of the incoming fetch address.
  assign if_idx = if_pc[INDEX_W+1:2];
  assign if_tag = if_pc[17:INDEX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // The line being refilled is always the one addressed by the outstanding
  // fetch, never the live if_pc (IF may change it during a miss).
  assign fill_idx = req_pc_q[INDEX_W+1:2];
  assign fill_tag = req_pc_q[17:INDEX_W+2];
  assign mc_match = mc_ok && (mc_pc == req_pc_q);

  // Byte-offset bits of the fetch address carry no information.
  assign unused_pc_bits = ^if_pc[1:0];

`ifdef ICACHE_PREFETCH_EN
  assign pf_idx = pf_pc_q[INDEX_W+1:2];
  assign pf_tag = pf_pc_q[17:INDEX_W+2];
  assign pf_hit = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
`endif

  // Next-state logic. When rdy is low every *_d equals its *_q, so nothing
  // moves; that includes if_ok, which is held rather than cleared.
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    if_ok_d   = if_ok_q;
    if_inst_d = if_inst_q;
    fill_en   = 1'b0;
`ifdef ICACHE_PREFETCH_EN
    pf_cand_d = pf_cand_q;
    pf_pc_d   = pf_pc_q;
`endif

    if (rdy) begin
      if_ok_d = 1'b0;
`ifdef ICACHE_PREFETCH_EN
      pf_cand_d = 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (if_req && !flush) begin
            if (if_hit) begin
              if_ok_d   = 1'b1;
              if_inst_d = data_q[if_idx];
            end else begin
              state_d  = S_MISS;
              req_pc_d = {if_pc[31:2], 2'b00};
              drop_d   = 1'b0;
            end
          end
`ifdef ICACHE_PREFETCH_EN
          else if (!if_req && pf_cand_q && !pf_hit) begin
            state_d  = S_PREFETCH;
            req_pc_d = pf_pc_q;
          end
`endif
        end

        S_MISS: begin
          // A redirect in any cycle of the miss, including the completion
          // cycle, suppresses the response but not the install.
          if (flush) begin
            drop_d = 1'b1;
          end
          if (mc_match) begin
            fill_en = 1'b1;
            state_d = S_IDLE;
            if (!drop_q && !flush) begin
              if_ok_d   = 1'b1;
              if_inst_d = mc_inst;
            end
`ifdef ICACHE_PREFETCH_EN
            pf_cand_d = 1'b1;
            pf_pc_d   = req_pc_q + 32'd4;
`endif
          end
        end

`ifdef ICACHE_PREFETCH_EN
        S_PREFETCH: begin
          // A demand request waits here. If it is for the prefetched word it
          // is answered straight from the fill; otherwise IDLE sees it next
          // cycle and starts an ordinary miss.
          if (mc_match) begin
            fill_en = 1'b1;
            state_d = S_IDLE;
            if (if_req && !flush && (if_pc[17:2] == req_pc_q[17:2])) begin
              if_ok_d   = 1'b1;
              if_inst_d = mc_inst;
            end
          end
        end
`endif

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_pc_q  <= '0;
      drop_q    <= 1'b0;
      if_ok_q   <= 1'b0;
      if_inst_q <= '0;
`ifdef ICACHE_PREFETCH_EN
      pf_cand_q <= 1'b0;
      pf_pc_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      drop_q    <= drop_d;
      if_ok_q   <= if_ok_d;
      if_inst_q <= if_inst_d;
`ifdef ICACHE_PREFETCH_EN
      pf_cand_q <= pf_cand_d;
      pf_pc_q   <= pf_pc_d;
`endif
    end
  end

  // Valid bits: cleared by reset, set by a fill. A reset during a miss
  // therefore leaves the line invalid even if the MC answers later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; a fill always overwrites its index.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_inst;
    end
  end

  assign if_ok   = if_ok_q;
  assign if_inst = if_inst_q;
  assign mc_fe   = (state_q != S_IDLE);
  assign mc_fpc  = req_pc_q;

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
//
// Self-checking bench for icache. A transaction-level model of the cache
// (a table of cached word addresses plus the one outstanding fetch) predicts
// if_ok / if_inst / mc_fe / mc_fpc each cycle. Directed sequences with
// literal expectations come first, then a randomized IF/MC traffic phase.
// The ICACHE_PREFETCH_EN macro enables the prefetch part of the model and a
// directed prefetch sequence.
// ---------------------------------------------------------------------------
module tb_icache;

  localparam int IW    = 8;
  localparam int LINES = 1 << IW;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_pc;
  logic        flush;
  logic        if_ok;
  logic [31:0] if_inst;
  logic        mc_fe;
  logic [31:0] mc_fpc;
  logic        mc_ok;
  logic [31:0] mc_pc;
  logic [31:0] mc_inst;

  int tests = 0;
  int fails = 0;

  // Model: which word address (pc[17:2]) each line holds, and its data.
  bit          mValid [LINES];
  logic [15:0] mKey   [LINES];
  logic [31:0] mData  [LINES];
  bit          pend;
  bit          pendPf;
  bit          pendDrop;
  logic [31:0] pendAddr;
  bit          pfCand;
  logic [31:0] pfAddr;
  bit          expOk;
  logic [31:0] expInst;
  bit          redirect;

  icache #(.INDEX_W(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .if_req  (if_req),
    .if_pc   (if_pc),
    .flush   (flush),
    .if_ok   (if_ok),
    .if_inst (if_inst),
    .mc_fe   (mc_fe),
    .mc_fpc  (mc_fpc),
    .mc_ok   (mc_ok),
    .mc_pc   (mc_pc),
    .mc_inst (mc_inst)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen through the MC; address 0 holds 0x00000013.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  function automatic bit mHit(input logic [31:0] a);
    return mValid[a[IW+1:2]] && (mKey[a[IW+1:2]] == a[17:2]);
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    pend     = 1'b0;
    pendPf   = 1'b0;
    pendDrop = 1'b0;
    pendAddr = '0;
    pfCand   = 1'b0;
    pfAddr   = '0;
    expOk    = 1'b0;
    expInst  = '0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic modelStep();
    bit          okNext;
    logic [31:0] instNext;
    if (!rst) begin
      modelReset();
    end else if (rdy) begin
      okNext   = 1'b0;
      instNext = expInst;
      if (!pend) begin
        if (if_req && !flush) begin
          if (mHit(if_pc)) begin
            okNext   = 1'b1;
            instNext = mData[if_pc[IW+1:2]];
          end else begin
            pend     = 1'b1;
            pendPf   = 1'b0;
            pendDrop = 1'b0;
            pendAddr = {if_pc[31:2], 2'b00};
          end
        end
`ifdef ICACHE_PREFETCH_EN
        else if (pfCand && !if_req && !mHit(pfAddr)) begin
          pend     = 1'b1;
          pendPf   = 1'b1;
          pendAddr = pfAddr;
        end
`endif
        pfCand = 1'b0;
      end else begin
        if (flush && !pendPf) pendDrop = 1'b1;
        if (mc_ok && mc_pc == pendAddr) begin
          mValid[pendAddr[IW+1:2]] = 1'b1;
          mKey[pendAddr[IW+1:2]]   = pendAddr[17:2];
          mData[pendAddr[IW+1:2]]  = mc_inst;
          pend = 1'b0;
          if (!pendPf) begin
            if (!pendDrop) begin
              okNext   = 1'b1;
              instNext = mc_inst;
            end
            pfCand = 1'b1;
            pfAddr = pendAddr + 32'd4;
          end else if (if_req && !flush && if_pc[17:2] == pendAddr[17:2]) begin
            okNext   = 1'b1;
            instNext = mc_inst;
          end
        end
      end
      expOk   = okNext;
      expInst = instNext;
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic checkOutput();
    compare("if_ok", if_ok, expOk);
    if (expOk) compare("if_inst", if_inst, expInst);
    compare("mc_fe", mc_fe, pend);
    if (pend) compare("mc_fpc", mc_fpc, pendAddr);
    if (!rst) begin
      compare("rst_if_inst", if_inst, 32'h0);
      compare("rst_mc_fpc", mc_fpc, 32'h0);
    end
  endtask

  // One clock: DUT and model take the edge, outputs are checked 1 unit later,
  // and control returns at the falling edge for the next input update.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Demand miss at pc with a one-cycle MC response, then a re-request hit.
  task automatic missFill(input logic [31:0] pc, input string tagName);
    if_req = 1'b1;
    if_pc  = pc;
    applyStimulus();
    compare({tagName, "_miss_fe"}, mc_fe, 1'b1);
    compare({tagName, "_miss_fpc"}, mc_fpc, {pc[31:2], 2'b00});
    mc_ok   = 1'b1;
    mc_pc   = {pc[31:2], 2'b00};
    mc_inst = memWord({pc[31:2], 2'b00});
    applyStimulus();
    mc_ok = 1'b0;
    compare({tagName, "_fill_ok"}, if_ok, 1'b1);
    compare({tagName, "_fill_inst"}, if_inst, memWord({pc[31:2], 2'b00}));
    compare({tagName, "_fill_fe_low"}, mc_fe, 1'b0);
    applyStimulus();
    compare({tagName, "_hit_ok"}, if_ok, 1'b1);
    compare({tagName, "_hit_fe"}, mc_fe, 1'b0);
  endtask

  task automatic newRequest();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 4) == 0) begin
      if_req = 1'b0;
    end else begin
      if_req = 1'b1;
      if_pc  = (r & 32'hFFFC_0003)
             | (32'($urandom_range(0, 2)) << 10)
             | (32'($urandom_range(0, 9)) << 2);
    end
  endtask

  // Directed sequences followed by randomized traffic.
  initial begin
    rst      = 1'b0;
    rdy      = 1'b1;
    if_req   = 1'b0;
    if_pc    = '0;
    flush    = 1'b0;
    mc_ok    = 1'b0;
    mc_pc    = '0;
    mc_inst  = '0;
    redirect = 1'b0;
    modelReset();

    // Reset values.
    applyStimulus();
    applyStimulus();
    compare("reset_if_ok", if_ok, 1'b0);
    compare("reset_if_inst", if_inst, 32'h0);
    compare("reset_mc_fe", mc_fe, 1'b0);
    compare("reset_mc_fpc", mc_fpc, 32'h0);
    rst = 1'b1;
    applyStimulus();

    // Cold miss at 0 returning 0x00000013, then hits.
    missFill(32'h0000_0000, "cold0");
    compare("cold0_literal_inst", if_inst, 32'h0000_0013);
    missFill(32'h0000_0004, "fill4");
    missFill(32'h0000_0008, "fill8");

    // Back-to-back hits, one per cycle.
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'(i * 4);
      applyStimulus();
      compare("b2b_ok", if_ok, 1'b1);
      compare("b2b_inst", if_inst, memWord(32'(i * 4)));
      compare("b2b_fe", mc_fe, 1'b0);
    end

    // Conflict: 0x400 evicts 0x000, which then misses again.
    missFill(32'h0000_0400, "conf400");
    missFill(32'h0000_0000, "conf000");

    // Flush during a miss: response dropped, line still installed.
    if_pc = 32'h0000_0010;
    applyStimulus();
    compare("flush_miss_fe", mc_fe, 1'b1);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    mc_ok   = 1'b1;
    mc_pc   = 32'h0000_0010;
    mc_inst = memWord(32'h0000_0010);
    applyStimulus();
    mc_ok = 1'b0;
    compare("flush_no_ok", if_ok, 1'b0);
    compare("flush_fe_low", mc_fe, 1'b0);
    applyStimulus();
    compare("flush_rehit_ok", if_ok, 1'b1);
    compare("flush_rehit_inst", if_inst, memWord(32'h0000_0010));

    // Mismatching mc_pc ignored, then rdy low for 3 cycles mid-miss.
    if_pc = 32'h0000_0030;
    applyStimulus();
    mc_ok   = 1'b1;
    mc_pc   = 32'h0000_0034;
    mc_inst = 32'hDEAD_BEEF;
    applyStimulus();
    mc_ok = 1'b0;
    compare("mismatch_fe", mc_fe, 1'b1);
    compare("mismatch_no_ok", if_ok, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      compare("rdy_low_fe", mc_fe, 1'b1);
      compare("rdy_low_fpc", mc_fpc, 32'h0000_0030);
    end
    rdy     = 1'b1;
    mc_ok   = 1'b1;
    mc_pc   = 32'h0000_0030;
    mc_inst = memWord(32'h0000_0030);
    applyStimulus();
    mc_ok = 1'b0;
    compare("rdy_resume_ok", if_ok, 1'b1);
    compare("rdy_resume_inst", if_inst, memWord(32'h0000_0030));

    // Reset in the middle of a miss.
    if_pc = 32'h0000_0040;
    applyStimulus();
    compare("rstmid_fe_before", mc_fe, 1'b1);
    rst = 1'b0;
    #1;
    compare("rstmid_fe_async", mc_fe, 1'b0);
    modelReset();
    applyStimulus();
    rst = 1'b1;
    missFill(32'h0000_0000, "postrst0");

`ifdef ICACHE_PREFETCH_EN
    // Prefetch of A+4 after a demand fill followed by an idle cycle.
    if_pc = 32'h0000_0020;
    applyStimulus();
    mc_ok   = 1'b1;
    mc_pc   = 32'h0000_0020;
    mc_inst = memWord(32'h0000_0020);
    applyStimulus();
    mc_ok  = 1'b0;
    if_req = 1'b0;
    applyStimulus();
    compare("pf_fe", mc_fe, 1'b1);
    compare("pf_fpc", mc_fpc, 32'h0000_0024);
    mc_ok   = 1'b1;
    mc_pc   = 32'h0000_0024;
    mc_inst = memWord(32'h0000_0024);
    applyStimulus();
    mc_ok = 1'b0;
    compare("pf_fill_no_ok", if_ok, 1'b0);
    compare("pf_fill_fe_low", mc_fe, 1'b0);
    if_req = 1'b1;
    if_pc  = 32'h0000_0024;
    applyStimulus();
    compare("pf_hit_ok", if_ok, 1'b1);
    compare("pf_hit_inst", if_inst, memWord(32'h0000_0024));
`endif

    // Randomized IF / MC traffic with flushes, stalls and stray completions.
    if_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      flush   = 1'b0;
      mc_ok   = 1'b0;
      mc_pc   = $urandom;
      mc_inst = $urandom;
      rdy     = ($urandom_range(0, 9) != 0);
      if (expOk || redirect) begin
        newRequest();
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        newRequest();
      end
      redirect = 1'b0;
      if (rdy && $urandom_range(0, 15) == 0) begin
        flush    = 1'b1;
        redirect = 1'b1;
      end
      if (pend && $urandom_range(0, 2) == 0) begin
        mc_ok   = 1'b1;
        mc_pc   = pendAddr;
        mc_inst = memWord(pendAddr);
      end else if ($urandom_range(0, 9) == 0) begin
        mc_ok = 1'b1;
        mc_pc = pendAddr ^ 32'h4;
      end
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
